instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Single-outstanding instruction fetch unit. Requests the word
//                at the program counter, waits for the memory response, and
//                holds the instruction for decode until it is accepted.
//                Branch/jump flushes discard in-flight or held work.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter int I_ADDR_W = 12,
   parameter int INSTR_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [I_ADDR_W-1:0] pc,
   output logic                pc_advance,
   input  logic                flush,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [I_ADDR_W-1:0] imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [INSTR_W-1:0]  imem_rsp_data,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instr_data,
   output logic [I_ADDR_W-1:0] instr_pc
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DROP = 3'd3,
      HOLD = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [I_ADDR_W-1:0]   r_fetch_pc;
   logic [INSTR_W-1:0]    r_instr_data;
   logic [I_ADDR_W-1:0]   r_instr_pc;
   logic                  w_capture_pc;
   logic                  w_load_instr;

   // State register; reset abandons any outstanding request or held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic, datapath strobes and handshake outputs.
   always_comb begin
      w_next_state   = r_state;
      w_capture_pc   = 1'b0;
      w_load_instr   = 1'b0;
      imem_req_valid = 1'b0;
      instr_valid    = 1'b0;
      pc_advance     = 1'b0;
      case (r_state)
         IDLE: begin
            w_next_state = REQ;
         end
         REQ: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
               if (flush) begin
                  // Address just issued is stale; its response must be eaten.
                  w_next_state = DROP;
               end else begin
                  w_capture_pc = 1'b1;
                  w_next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (flush) begin
               // Response in the same cycle is simply discarded.
               w_next_state = imem_rsp_valid ? REQ : DROP;
            end else if (imem_rsp_valid) begin
               w_load_instr = 1'b1;
               w_next_state = HOLD;
            end
         end
         DROP: begin
            // The one outstanding response retires the drop even if a new
            // flush arrives with it; waiting longer would never terminate.
            if (imem_rsp_valid) begin
               w_next_state = REQ;
            end else if (flush) begin
               w_next_state = DROP;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (flush) begin
               w_next_state = REQ;
            end else if (instr_ready) begin
               pc_advance   = 1'b1;
               w_next_state = REQ;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Address of the accepted request, remembered until its response lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= '0;
      end else if (w_capture_pc) begin
         r_fetch_pc <= pc;
      end
   end

   // Instruction word and its address presented to decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_data <= '0;
         r_instr_pc   <= '0;
      end else if (w_load_instr) begin
         r_instr_data <= imem_rsp_data;
         r_instr_pc   <= r_fetch_pc;
      end
   end

   // Request address follows pc directly; no arithmetic on the address.
   always_comb begin
      imem_req_addr = imem_req_valid ? pc : '0;
   end

   assign instr_data = r_instr_data;
   assign instr_pc   = r_instr_pc;

endmodule
`default_nettype wire
